// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder (WIDTH steps each).
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_LESS = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRL  = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MUL  = 4'b1100,
        OP_DIVU = 4'b1110,
        OP_REMU = 4'b1111
    } op_e;

    state_e           state, state_nxt;
    logic [3:0]       op_reg;
    logic [SHW-1:0]   cnt;
    // a_reg: accumulator (MUL) / partial remainder (DIV)
    // b_reg: shifted multiplicand (MUL) / divisor (DIV)
    // q_reg: multiplier shifted right (MUL) / dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] a_reg, b_reg, q_reg;

    logic             accept, step, is_iter;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_sum, div_diff, div_rem, div_quo, final_res;
    logic [WIDTH:0]   div_tmp;
    logic             div_ge;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);
    assign is_iter   = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
    assign sh        = op2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_LESS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SRL:  alu_res = op1 >> sh;
            OP_SLL:  alu_res = op1 << sh;
            OP_SRA:  alu_res = $signed(op1) >>> sh;
            default: alu_res = '0;
        endcase
    end

    // A zero divisor needs no special case: every trial subtract succeeds, so the
    // quotient fills with ones and the remainder shifts in the whole dividend.
    always_comb begin
        mul_sum  = a_reg + (q_reg[0] ? b_reg : '0);
        div_tmp  = {a_reg, q_reg[WIDTH-1]};
        div_ge   = (div_tmp >= {1'b0, b_reg});
        div_diff = div_tmp[WIDTH-1:0] - b_reg;
        div_rem  = div_ge ? div_diff : div_tmp[WIDTH-1:0];
        div_quo  = {q_reg[WIDTH-2:0], div_ge};
        case (op_reg)
            OP_MUL:  final_res = mul_sum;
            OP_DIVU: final_res = div_quo;
            default: final_res = div_rem;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = is_iter ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    step = 1'b1;
                    if (cnt == '0) state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg <= '0;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            q_reg  <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else if (accept) begin
            op_reg <= alu_op;
            cnt    <= SHW'(WIDTH - 1);
            a_reg  <= '0;
            if (alu_op == OP_MUL) begin
                b_reg <= op1;
                q_reg <= op2;
            end else begin
                b_reg <= op2;
                q_reg <= op1;
            end
            if (!is_iter) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
            end
        end else if (step) begin
            cnt <= cnt - SHW'(1);
            if (op_reg == OP_MUL) begin
                a_reg <= mul_sum;
                b_reg <= b_reg << 1;
                q_reg <= q_reg >> 1;
            end else begin
                a_reg <= div_rem;
                q_reg <= div_quo;
            end
            if (cnt == '0) begin
                result <= final_res;
                zero   <= (final_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv_w, ir_w, ov_w, ordy_w, fl_w, z_w, bz_w;
    logic [31:0] a_w, b_w, r_w;
    logic [3:0]  op_w;
    logic        iv_n, ir_n, ov_n, ordy_n, fl_n, z_n, bz_n;
    logic [7:0]  a_n, b_n, r_n;
    logic [3:0]  op_n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(32)) u_wide (
        .clk(clk), .rst(rst), .in_valid(iv_w), .in_ready(ir_w), .op1(a_w), .op2(b_w),
        .alu_op(op_w), .flush(fl_w), .out_valid(ov_w), .out_ready(ordy_w),
        .result(r_w), .zero(z_w), .busy(bz_w)
    );

    alu_seq #(.WIDTH(8)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(iv_n), .in_ready(ir_n), .op1(a_n), .op2(b_n),
        .alu_op(op_n), .flush(fl_n), .out_valid(ov_n), .out_ready(ordy_n),
        .result(r_n), .zero(z_n), .busy(bz_n)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic longint unsigned model(input int w, input logic [3:0] op,
                                              input longint unsigned a, input longint unsigned b);
        longint unsigned mask;
        longint sa, sb;
        int sh;
        mask = (64'd1 << w) - 1;
        sa = $signed(a);
        sb = $signed(b);
        if (a[w-1]) sa = sa - (64'sd1 <<< w);
        if (b[w-1]) sb = sb - (64'sd1 <<< w);
        sh = int'(b % longint'(w));
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return (a + b) & mask;
            4'b0110: return (a - b) & mask;
            4'b0101: return a ^ b;
            4'b0100: return (sa < sb) ? 1 : 0;
            4'b1000: return a >> sh;
            4'b1001: return (a << sh) & mask;
            4'b1010: return $unsigned(sa >>> sh) & mask;
            4'b1100: return (a * b) & mask;
            4'b1110: return (b == 0) ? mask : a / b;
            4'b1111: return (b == 0) ? a : a % b;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [3:0] op,
                         input longint unsigned a, input longint unsigned b);
        if (w == 32) begin
            iv_w = v; op_w = op; a_w = a[31:0]; b_w = b[31:0];
        end else begin
            iv_n = v; op_n = op; a_n = a[7:0]; b_n = b[7:0];
        end
    endtask

    task automatic set_ctl(input int w, input logic ordy, input logic fl);
        if (w == 32) begin ordy_w = ordy; fl_w = fl; end
        else begin ordy_n = ordy; fl_n = fl; end
    endtask

    task automatic peek(input int w, output logic ov, output logic ir, output logic bz,
                        output longint unsigned res, output logic z);
        if (w == 32) begin ov = ov_w; ir = ir_w; bz = bz_w; res = r_w; z = z_w; end
        else begin ov = ov_n; ir = ir_n; bz = bz_n; res = r_n; z = z_n; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge; leaves the DUT in DONE.
    task automatic start_op(input int w, input logic [3:0] op, input longint unsigned a,
                            input longint unsigned b, output int lat, output int bcnt,
                            output longint unsigned res, output logic z);
        logic ov, ir, bz;
        int guard;
        guard = 0;
        peek(w, ov, ir, bz, res, z);
        while (!ir && guard < 200) begin
            tick();
            guard++;
            peek(w, ov, ir, bz, res, z);
        end
        check("in_ready_wait", ir, 1);
        drive(w, 1'b1, op, a, b);
        tick();
        drive(w, 1'b0, 4'($urandom), $urandom, $urandom);
        lat  = 1;
        bcnt = 0;
        peek(w, ov, ir, bz, res, z);
        while (!ov && lat < 100) begin
            if (bz) bcnt++;
            tick();
            lat++;
            peek(w, ov, ir, bz, res, z);
        end
        check("out_valid_wait", ov, 1);
    endtask

    task automatic consume(input int w);
        logic ov, ir, bz, z;
        longint unsigned res;
        set_ctl(w, 1'b1, 1'b0);
        tick();
        set_ctl(w, 1'b0, 1'b0);
        peek(w, ov, ir, bz, res, z);
        check("consume_out_valid", ov, 0);
        check("consume_in_ready", ir, 1);
    endtask

    task automatic do_op(input int w, input logic [3:0] op, input longint unsigned a,
                         input longint unsigned b, input string tag);
        int lat, bcnt;
        longint unsigned res, exp, mask;
        logic z;
        mask = (64'd1 << w) - 1;
        a = a & mask;
        b = b & mask;
        exp = model(w, op, a, b);
        start_op(w, op, a, b, lat, bcnt, res, z);
        check({tag, "_result"}, res, exp);
        check({tag, "_zero"}, z, (exp == 0) ? 1 : 0);
        check({tag, "_latency"}, lat, is_iter(op) ? w + 1 : 1);
        check({tag, "_busy_cycles"}, bcnt, is_iter(op) ? w : 0);
        consume(w);
    endtask

    logic [3:0] op_tab [13] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h5, 4'h4, 4'h8, 4'h9,
                                4'hA, 4'hC, 4'hE, 4'hF, 4'h7};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov, ir, bz, z;
        longint unsigned res, r0, b;
        int lat, bcnt, hits;
        logic [3:0] op;

        rst = 1'b1;
        drive(32, 1'b0, 4'h0, 0, 0);
        drive(8, 1'b0, 4'h0, 0, 0);
        set_ctl(32, 1'b0, 1'b0);
        set_ctl(8, 1'b0, 1'b0);
        repeat (2) tick();
        peek(32, ov, ir, bz, res, z);
        check("rst_out_valid", ov, 0);
        check("rst_busy", bz, 0);
        check("rst_in_ready", ir, 1);
        check("rst_result", res, 0);
        check("rst_zero", z, 0);
        rst = 1'b0;

        do_op(32, 4'b0110, 5, 5, "sub_eq");
        do_op(32, 4'b0100, 32'hFFFF_FFFF, 1, "less_neg");
        do_op(32, 4'b1010, 32'h8000_0000, 32'h24, "sra");
        do_op(32, 4'b0111, $urandom, $urandom, "illegal_op");
        do_op(32, 4'b1100, 32'h1_0000, 32'h1_0001, "mul_wrap");
        do_op(32, 4'b1110, 100, 7, "divu");
        do_op(32, 4'b1111, 100, 7, "remu");
        do_op(32, 4'b1110, 5, 0, "divu_by0");
        do_op(32, 4'b1111, 5, 0, "remu_by0");
        do_op(8, 4'b1100, 8'h0F, 8'h11, "n_mul");
        do_op(8, 4'b1001, 1, 8'h0B, "n_sll");
        do_op(8, 4'b1110, 8'hC8, 8'h0D, "n_divu");

        // Backpressure: DONE must hold with result frozen.
        start_op(32, 4'b0010, 32'h1234_5678, 32'h1111_1111, lat, bcnt, r0, z);
        for (int i = 0; i < 10; i++) begin
            tick();
            peek(32, ov, ir, bz, res, z);
            check("bp_out_valid", ov, 1);
            check("bp_in_ready", ir, 0);
            check("bp_result", res, 64'h2345_6789);
        end
        consume(32);

        // Flush mid-multiply: back to IDLE, no result, result unchanged.
        drive(32, 1'b1, 4'b1100, 32'hDEAD, 32'hBEEF);
        tick();
        drive(32, 1'b0, 4'h0, 0, 0);
        repeat (3) tick();
        set_ctl(32, 1'b1, 1'b1);
        tick();
        set_ctl(32, 1'b0, 1'b0);
        peek(32, ov, ir, bz, res, z);
        check("flush_busy", bz, 0);
        check("flush_in_ready", ir, 1);
        check("flush_out_valid", ov, 0);
        check("flush_result_held", res, 64'h2345_6789);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ov_w) hits++;
        end
        check("flush_no_valid_pulse", hits, 0);

        // Flush in IDLE blocks acceptance.
        drive(32, 1'b1, 4'b0010, 1, 1);
        set_ctl(32, 1'b0, 1'b1);
        tick();
        drive(32, 1'b0, 4'h0, 0, 0);
        set_ctl(32, 1'b0, 1'b0);
        peek(32, ov, ir, bz, res, z);
        check("flush_idle_no_accept", ov, 0);
        check("flush_idle_in_ready", ir, 1);

        // Flush together with out_ready in DONE.
        start_op(32, 4'b0101, 32'hF0F0, 32'h0F0F, lat, bcnt, r0, z);
        set_ctl(32, 1'b1, 1'b1);
        tick();
        set_ctl(32, 1'b0, 1'b0);
        peek(32, ov, ir, bz, res, z);
        check("flush_done_out_valid", ov, 0);
        check("flush_done_in_ready", ir, 1);
        check("flush_done_result", res, 64'hFFFF);

        // Asynchronous reset in the middle of a multiply.
        drive(32, 1'b1, 4'b1100, 7, 9);
        tick();
        drive(32, 1'b0, 4'h0, 0, 0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        peek(32, ov, ir, bz, res, z);
        check("mrst_out_valid", ov, 0);
        check("mrst_busy", bz, 0);
        check("mrst_result", res, 0);
        check("mrst_zero", z, 0);
        check("mrst_in_ready", ir, 1);
        tick();
        rst = 1'b0;
        do_op(32, 4'b0010, 3, 4, "post_rst_add");

        for (int i = 0; i < 40; i++) begin
            op = op_tab[$urandom_range(0, 12)];
            b = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 9)) : longint'($urandom);
            do_op(32, op, $urandom, b, "rand_w");
        end
        for (int i = 0; i < 30; i++) begin
            op = op_tab[$urandom_range(0, 12)];
            b = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 3)) : longint'($urandom);
            do_op(8, op, $urandom, b, "rand_n");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
